// File: rtl/sqrt_pipe.sv
// sqrt_pipe: fully pipelined unsigned integer square root with valid/ready
// handshake, global stall, sideband tag, optional round-to-nearest.
//
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   in_valid/in_ready       operand handshake (in_ready = pipeline advance)
//   in_data [IN_W]          unsigned operand
//   in_tag  [TAG_W]         sideband tag carried with the operand
//   out_valid/out_ready     result handshake
//   out_data [RW+FRAC_BITS] root << FRAC_BITS
//   out_rem  [RW+1]         operand - floor_root^2
//   out_exact               operand is a perfect square
//   out_tag  [TAG_W]        tag captured with the operand
//   busy                    any stage holds a valid entry
module sqrt_pipe #(
    parameter int IN_W           = 32,
    parameter int BITS_PER_STAGE = 4,
    parameter int FRAC_BITS      = 16,
    parameter int TAG_W          = 4,
    parameter int ROUND          = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [IN_W-1:0]               in_data,
    input  logic [TAG_W-1:0]              in_tag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [IN_W/2+FRAC_BITS-1:0]   out_data,
    output logic [IN_W/2:0]               out_rem,
    output logic                          out_exact,
    output logic [TAG_W-1:0]              out_tag,
    output logic                          busy
);

    localparam int RW = IN_W / 2;
    localparam int NS = RW / BITS_PER_STAGE;
    // Two spare bits so the trial subtrahend never wraps.
    localparam int CW = IN_W + 2;

    typedef struct packed {
        logic [RW-1:0]   root;
        logic [IN_W-1:0] rem;
    } acc_t;

    acc_t             st_q  [NS];
    acc_t             st_d  [NS];
    logic [TAG_W-1:0] tag_q [NS];
    logic [NS-1:0]    vld_q;
    acc_t             seed;
    logic             advance;

    // Resolve BITS_PER_STAGE root bits for stage k.
    // Setting bit b grows root^2 by (root << (b+1)) + (1 << 2b); the bit is
    // kept when the running remainder can absorb that increment.
    function automatic acc_t resolve(input acc_t a, input int k);
        acc_t          r;
        logic [CW-1:0] trial;
        int            b;
        r = a;
        for (int j = 0; j < BITS_PER_STAGE; j++) begin
            b     = RW - 1 - k * BITS_PER_STAGE - j;
            trial = (CW'(r.root) << (b + 1)) + (CW'(1) << (2 * b));
            if (CW'(r.rem) >= trial) begin
                r.rem  = r.rem - trial[IN_W-1:0];
                r.root = r.root | (RW'(1) << b);
            end
        end
        return r;
    endfunction

    assign seed    = {{RW{1'b0}}, in_data};
    assign advance = !vld_q[NS-1] || out_ready;
    assign in_ready = advance;

    always_comb begin
        st_d[0] = resolve(seed, 0);
        for (int k = 1; k < NS; k++) begin
            st_d[k] = resolve(st_q[k-1], k);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            for (int k = 0; k < NS; k++) begin
                st_q[k]  <= '0;
                tag_q[k] <= '0;
            end
        end else if (advance) begin
            vld_q[0] <= in_valid;
            tag_q[0] <= in_tag;
            st_q[0]  <= st_d[0];
            for (int k = 1; k < NS; k++) begin
                vld_q[k] <= vld_q[k-1];
                tag_q[k] <= tag_q[k-1];
                st_q[k]  <= st_d[k];
            end
        end
    end

    // Output stage: last pipeline register plus rounding.
    logic [RW-1:0]   root_f;
    logic [IN_W-1:0] rem_f;
    logic [RW-1:0]   root_r;
    logic            round_up;

    assign root_f = st_q[NS-1].root;
    assign rem_f  = st_q[NS-1].rem;

    // rem > root  <=>  operand > root^2 + root, i.e. nearer to root+1.
    always_comb begin
        round_up = (ROUND != 0) && (rem_f > IN_W'(root_f));
        root_r   = root_f;
        if (round_up && (root_f != '1)) begin
            root_r = root_f + RW'(1);
        end
    end

    assign out_valid = vld_q[NS-1];
    assign out_data  = {root_r, {FRAC_BITS{1'b0}}};
    assign out_rem   = rem_f[RW:0];
    assign out_exact = vld_q[NS-1] && (rem_f == '0);
    assign out_tag   = tag_q[NS-1];
    assign busy      = |vld_q;

endmodule

// File: tb/tb_sqrt_pipe.sv
// tb_sqrt_pipe: directed self-checking bench for sqrt_pipe, floor and
// round-to-nearest instances, handshake, stall, bubble and reset cases.
module tb_sqrt_pipe;

    logic        clock = 1'b0;
    logic        reset;

    logic        in_valid, out_ready;
    logic [31:0] in_data;
    logic [3:0]  in_tag;
    logic        in_ready, out_valid, out_exact, busy;
    logic [31:0] out_data;
    logic [16:0] out_rem;
    logic [3:0]  out_tag;

    logic        in_valid_r, out_ready_r;
    logic [31:0] in_data_r;
    logic [3:0]  in_tag_r;
    logic        in_ready_r, out_valid_r, out_exact_r, busy_r;
    logic [31:0] out_data_r;
    logic [16:0] out_rem_r;
    logic [3:0]  out_tag_r;

    int checks = 0;
    int errors = 0;

    sqrt_pipe #(.ROUND(0)) u_floor (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rem   (out_rem),
        .out_exact (out_exact),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    sqrt_pipe #(.ROUND(1)) u_round (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid_r),
        .in_ready  (in_ready_r),
        .in_data   (in_data_r),
        .in_tag    (in_tag_r),
        .out_valid (out_valid_r),
        .out_ready (out_ready_r),
        .out_data  (out_data_r),
        .out_rem   (out_rem_r),
        .out_exact (out_exact_r),
        .out_tag   (out_tag_r),
        .busy      (busy_r)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [31:0] s_in   [4] = '{32'd0, 32'd1, 32'd15, 32'd16};
    logic [31:0] s_data [4] = '{32'h0, 32'h10000, 32'h30000, 32'h40000};
    logic [16:0] s_rem  [4] = '{17'd0, 17'd0, 17'd6, 17'd0};
    logic        s_ex   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

    int sent;
    int pulses;
    int last;
    int cnt;

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        in_tag      = '0;
        out_ready   = 1'b1;
        in_valid_r  = 1'b0;
        in_data_r   = '0;
        in_tag_r    = '0;
        out_ready_r = 1'b1;

        // Reset state
        #12;
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_in_ready", 64'(in_ready), 1);
        chk("rst_out_data", 64'(out_data), 0);
        chk("rst_out_rem", 64'(out_rem), 0);
        chk("rst_out_exact", 64'(out_exact), 0);
        chk("rst_out_tag", 64'(out_tag), 0);
        chk("rst_busy_r", 64'(busy_r), 0);
        chk("rst_in_ready_r", 64'(in_ready_r), 1);
        reset = 1'b0;
        tick();

        // Back-to-back stream 0, 1, 15, 16
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = s_in[i];
            in_tag   = 4'(i);
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("stream_valid%0d", i), 64'(out_valid), 1);
            chk($sformatf("stream_data%0d", i), 64'(out_data),
                64'(s_data[i]));
            chk($sformatf("stream_rem%0d", i), 64'(out_rem),
                64'(s_rem[i]));
            chk($sformatf("stream_exact%0d", i), 64'(out_exact),
                64'(s_ex[i]));
            chk($sformatf("stream_tag%0d", i), 64'(out_tag), 64'(i));
            tick();
        end
        chk("stream_drained", 64'(out_valid), 0);

        // Largest operand
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        in_tag   = 4'd9;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk("max_valid", 64'(out_valid), 1);
        chk("max_data", 64'(out_data), 64'h0000_0000_FFFF_0000);
        chk("max_rem", 64'(out_rem), 131070);
        chk("max_exact", 64'(out_exact), 0);
        chk("max_tag", 64'(out_tag), 9);
        tick();

        // Round-to-nearest instance
        in_valid_r = 1'b1;
        in_data_r  = 32'd20;
        in_tag_r   = 4'd1;
        tick();
        in_data_r  = 32'd21;
        in_tag_r   = 4'd2;
        tick();
        in_data_r  = 32'hFFFF_FFFF;
        in_tag_r   = 4'd3;
        tick();
        in_valid_r = 1'b0;
        tick();
        chk("rnd20_valid", 64'(out_valid_r), 1);
        chk("rnd20_data", 64'(out_data_r), 64'h4_0000);
        chk("rnd20_rem", 64'(out_rem_r), 4);
        chk("rnd20_exact", 64'(out_exact_r), 0);
        chk("rnd20_tag", 64'(out_tag_r), 1);
        tick();
        chk("rnd21_data", 64'(out_data_r), 64'h5_0000);
        chk("rnd21_rem", 64'(out_rem_r), 5);
        chk("rnd21_tag", 64'(out_tag_r), 2);
        tick();
        chk("rndmax_data", 64'(out_data_r), 64'h0000_0000_FFFF_0000);
        chk("rndmax_rem", 64'(out_rem_r), 131070);
        chk("rndmax_tag", 64'(out_tag_r), 3);
        tick();
        chk("rnd_drained", 64'(out_valid_r), 0);

        // Backpressure: 100..105, stall on first result
        sent = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(100 + i);
            in_tag   = 4'(i);
            tick();
        end
        sent      = 4;
        in_data   = 32'd104;
        in_tag    = 4'd4;
        out_ready = 1'b0;
        #1;
        chk("bp_in_ready_drop", 64'(in_ready), 0);
        chk("bp_valid", 64'(out_valid), 1);
        chk("bp_data", 64'(out_data), 64'hA_0000);
        chk("bp_rem", 64'(out_rem), 0);
        chk("bp_tag", 64'(out_tag), 0);
        repeat (3) tick();
        chk("bp_hold_in_ready", 64'(in_ready), 0);
        chk("bp_hold_valid", 64'(out_valid), 1);
        chk("bp_hold_data", 64'(out_data), 64'hA_0000);
        chk("bp_hold_rem", 64'(out_rem), 0);
        chk("bp_hold_tag", 64'(out_tag), 0);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_back", 64'(in_ready), 1);
        for (int r = 0; r < 6; r++) begin
            chk($sformatf("bp_out_valid%0d", r), 64'(out_valid), 1);
            chk($sformatf("bp_out_data%0d", r), 64'(out_data),
                64'hA_0000);
            chk($sformatf("bp_out_rem%0d", r), 64'(out_rem), 64'(r));
            chk($sformatf("bp_out_tag%0d", r), 64'(out_tag), 64'(r));
            tick();
            if (in_valid) sent++;
            if (sent < 6) begin
                in_data = 32'(100 + sent);
                in_tag  = 4'(sent);
            end else begin
                in_valid = 1'b0;
            end
        end
        chk("bp_no_dup", 64'(out_valid), 0);
        chk("bp_idle", 64'(busy), 0);

        // Bubbles: alternate in_valid over 8 cycles
        pulses = 0;
        last   = -1;
        for (int c = 0; c < 16; c++) begin
            in_valid = (c < 8) && (c % 2 == 0);
            in_data  = 32'd25;
            in_tag   = 4'(c);
            tick();
            if (out_valid) begin
                pulses++;
                chk($sformatf("bub_data%0d", c), 64'(out_data),
                    64'h5_0000);
                if (last >= 0) begin
                    chk($sformatf("bub_gap%0d", c), 64'(c - last), 2);
                end
                last = c;
            end
        end
        in_valid = 1'b0;
        chk("bub_pulses", 64'(pulses), 4);

        // Reset with three operands in flight
        in_valid = 1'b1;
        in_data  = 32'd64;
        in_tag   = 4'd1;
        tick();
        in_data  = 32'd81;
        in_tag   = 4'd2;
        tick();
        in_data  = 32'd36;
        in_tag   = 4'd3;
        tick();
        in_valid = 1'b0;
        chk("mid_busy", 64'(busy), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 0);
        chk("mid_rst_busy", 64'(busy), 0);
        chk("mid_rst_in_ready", 64'(in_ready), 1);
        @(posedge clock);
        #3;
        reset = 1'b0;
        cnt = 0;
        repeat (8) begin
            tick();
            if (out_valid) cnt++;
        end
        chk("mid_no_ghosts", 64'(cnt), 0);
        in_valid = 1'b1;
        in_data  = 32'd49;
        in_tag   = 4'd5;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk("post_valid", 64'(out_valid), 1);
        chk("post_data", 64'(out_data), 64'h7_0000);
        chk("post_rem", 64'(out_rem), 0);
        chk("post_exact", 64'(out_exact), 1);
        chk("post_tag", 64'(out_tag), 5);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/sqrt_pipe.md
Name: sqrt_pipe

Overview:
- Parametrised, fully pipelined integer square-root unit for the sum-of-squares / vector-magnitude datapath.
- Computes floor or rounded sqrt of an unsigned IN_W-bit operand, plus remainder and exactness flag.
- Output is left-aligned into fixed-point format with FRAC_BITS fractional bits.
- Uses a valid/ready handshake with global-stall backpressure and a tag passed alongside each operand, so downstream can reorder or attribute results.

Parameters:
- IN_W, 32, operand width; must be even.
- BITS_PER_STAGE, 4, root bits resolved per pipeline stage; must divide IN_W/2.
- FRAC_BITS, 16, left shift applied to the integer root on out_data.
- TAG_W, 4, width of the sideband tag carried with each operand.
- ROUND, 0, 0 = floor(sqrt); 1 = round-to-nearest.
- Derived: RW = IN_W/2 (root width); NS = RW/BITS_PER_STAGE (stage count, 4 by default).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operand present
- in_ready  out  1  unit accepts operand this cycle
- in_data  in  IN_W  unsigned operand
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_data  out  RW+FRAC_BITS  root << FRAC_BITS
- out_rem  out  RW+1  in_data - floor_root^2, range 0..2*floor_root
- out_exact  out  1  out_rem == 0 (perfect square)
- out_tag  out  TAG_W  tag of this result
- busy  out  1  any stage holds a valid entry

Behaviour:
- Reset is asynchronous, active-high.
  - All stage valid bits, out_valid, out_data, out_rem, out_exact, out_tag and busy are cleared to 0.
  - in_ready is 1 after reset.
  - Asserting reset mid-operation discards all in-flight operands; nothing is emitted after release.
- Pipeline: NS stages. Stage k resolves root bits [RW-1-k*BPS : RW-k*BPS-BPS].
  - Arithmetic is digit-by-digit shift/subtract on a running remainder. No multipliers.
  - Each stage carries value, partial root, remainder, tag and valid.
- advance = !out_valid || out_ready. in_ready = advance.
  - All stages shift together when advance=1 and hold when advance=0 (global stall).
- Acceptance: an operand is accepted on a cycle where in_valid && in_ready.
  - When in_valid=0 while advancing, a bubble (valid=0) enters stage 0.
  - Bubbles propagate and never produce out_valid.
- Latency: an operand accepted at edge t appears with out_valid=1 after edge t+NS-1 when there are no stalls, i.e. NS register stages (stage NS-1 is the output register).
  - Throughput is one result per cycle.
- Output hold: while out_valid && !out_ready, out_data, out_rem, out_exact and out_tag are held stable.
- Simultaneous events:
  - Output pop and input accept in the same cycle are both legal and are the normal streaming case.
  - in_valid held high during a stall must not duplicate or drop the operand.
- Rounding:
  - ROUND=0: root = floor_root.
  - ROUND=1: root = floor_root + 1 if out_rem > floor_root, else floor_root.
    - If that sum overflows RW bits, root saturates to 2^RW-1.
  - out_rem and out_exact always refer to floor_root, regardless of ROUND.
- Width rule: out_data = {root, FRAC_BITS zeros}. No truncation; the width is exactly RW+FRAC_BITS.
- Order: results leave in acceptance order. out_tag equals the in_tag captured with the operand.
- busy = OR of all stage valid bits, including the output register.

Test Plan:
- Defaults, out_ready=1; stream in_data 0, 1, 15, 16 back-to-back, tags 0–3 -> four results on consecutive cycles, first NS cycles after the first accept:
  - data 0x00000000, 0x00010000, 0x00030000, 0x00040000
  - rem 0, 0, 6, 0
  - exact 1, 1, 0, 1
  - tags 0, 1, 2, 3
- in_data 0xFFFFFFFF -> out_data 0xFFFF0000, out_rem 131070, out_exact 0.
- ROUND=1: in_data 20 -> root 4 (0x00040000); 21 -> root 5 (0x00050000); 0xFFFFFFFF -> saturates to 0xFFFF0000, rem 131070.
- Backpressure:
  - Drive 6 operands 100..105 with out_ready=0 from the first out_valid -> in_ready drops the same cycle; outputs stay frozen on sqrt(100)=10.
  - Release out_ready -> results 10, 10, 10, 10, 10, 10 emitted in order with correct rem 0, 1, 2, 3, 4, 5 and no duplicates or losses.
- Bubbles: alternate in_valid 1/0 over 8 cycles -> exactly 4 out_valid pulses, spaced 2 cycles apart.
- Reset mid-flight: assert reset asynchronously (between edges) with 3 operands in flight -> out_valid and busy go to 0 immediately; no results appear after release; the next operand 49 returns 7 after NS cycles.
